// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges inst/data request ports onto one memory port, one transaction in flight; MEM_ARB_TIMEOUT_EN adds a watchdog
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W/8-1:0] we_q;
  logic [DATA_W-1:0] wdata_q;
  logic tag_q, wr_q, to, fin;
  logic [DATA_W-1:0] rval;
  // Acceptance is combinational from the request lines; data wins, and reset forces it low.
  assign data_addr_ok = (state == IDLE) && data_req && !reset;
  assign inst_addr_ok = (state == IDLE) && inst_req && !data_req && !reset;
  assign mem_req = (state == REQ);
  assign mem_addr = addr_q;
  assign mem_we = we_q;
  assign mem_wdata = wdata_q;
  assign inst_data_ok = (state == DONE) && !tag_q;
  assign data_data_ok = (state == DONE) && tag_q;
  assign fin = ((state == RESP) && mem_rvalid) || to;
  assign rval = to ? '0 : mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [9:0] cnt;
  logic err_q;
  assign to = ((state == REQ) || (state == RESP)) && !((state == RESP) && mem_rvalid)
              && (cnt == 10'(TIMEOUT_CYCLES - 1));
  assign mem_err = (state == DONE) && err_q;
  // Watchdog counts cycles spent in REQ/RESP; err flag marks a DONE reached by timeout.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= ((state == REQ) || (state == RESP)) ? cnt + 10'd1 : '0;
      err_q <= to;
    end
`else
  assign to = 1'b0;
  assign mem_err = 1'b0;
`endif
  // Next-state: accept, wait for grant, wait for response, pulse data_ok.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (data_req || inst_req) ? REQ : IDLE;
      REQ:  state_n = to ? DONE : mem_gnt ? RESP : REQ;
      RESP: state_n = fin ? DONE : RESP;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Latch the winning request and steer the response into the originating port.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      we_q <= '0;
      wdata_q <= '0;
      tag_q <= 1'b0;
      wr_q <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      state <= state_n;
      if (inst_addr_ok || data_addr_ok) begin
        addr_q <= data_req ? data_addr : inst_addr;
        we_q <= (data_req && data_wr) ? data_wstrb : '0;
        wdata_q <= data_req ? data_wdata : '0;
        tag_q <= data_req;
        wr_q <= data_req && data_wr;
      end
      if (fin && !tag_q) inst_rdata <= rval;
      if (fin && tag_q && !wr_q) data_rdata <= rval;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a response scoreboard and a small memory model
module tb_mem_port_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TOC = 8;
`else
  localparam int TOC = 255;
`endif
  logic clk, reset;
  logic inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0] data_wstrb, mem_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic mem_req, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic port; logic [31:0] rdata;} exp_t;
  exp_t q[$];
  int serr = 0, schk = 0, merr = 0, mchk = 0;
  int stall = 0;
  logic resp_en = 1'b1, stray = 1'b0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h1C00_0000: return 32'h0280_0C0C;
      32'h1C00_0004: return 32'h1234_5678;
      32'h0000_0200: return 32'hCAFE_F00D;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // memory: grant after `stall` refused cycles, answer the cycle after the grant
  initial begin
    int sc;
    logic pend;
    sc = 0;
    pend = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = (pend && resp_en) || stray;
      mem_rdata = rom(mem_addr);
      pend = 1'b0;
      if (reset) begin
        sc = 0;
        mem_gnt = 1'b0;
      end else if (mem_req) begin
        if (sc < stall) begin
          mem_gnt = 1'b0;
          sc++;
        end else begin
          mem_gnt = 1'b1;
          sc = 0;
          pend = 1'b1;
        end
      end else mem_gnt = 1'b0;
    end
  end

  // monitor: every data_ok must match the oldest expected response
  always @(negedge clk) begin
    if (inst_data_ok || data_data_ok) begin
      mchk++;
      if (inst_data_ok && data_data_ok) begin
        merr++;
        $display("FAIL mon both data_ok high");
      end else if (q.size() == 0) begin
        merr++;
        $display("FAIL mon unexpected data_ok port=%0d", data_data_ok);
      end else begin
        exp_t e;
        logic [31:0] got;
        e = q.pop_front();
        got = data_data_ok ? data_rdata : inst_rdata;
        if (e.port !== data_data_ok || got !== e.rdata) begin
          merr++;
          $display("FAIL mon resp: port=%0d rdata=%h want port=%0d rdata=%h",
                   data_data_ok, got, e.port, e.rdata);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    schk++;
    if (act !== exp) begin
      serr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic p, input logic [31:0] v);
    exp_t e;
    e.port = p;
    e.rdata = v;
    q.push_back(e);
  endtask

  task automatic wait_dok(input string nm);
    int n;
    n = 0;
    while (!(inst_data_ok || data_data_ok) && n < 40) begin
      step();
      #1;
      n++;
    end
    chk(nm, 32'(n < 40), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b1;
    data_req = 1'b1;
    inst_addr = 32'h1C00_0000;
    data_addr = 32'h0000_0200;
    data_wr = 1'b1;
    data_wstrb = 4'hF;
    data_wdata = 32'h5555_5555;
    step(); #1;
    chk("rst inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("rst data_addr_ok", 32'(data_addr_ok), 0);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst rdata", inst_rdata | data_rdata, 0);
    chk("rst mem_err", 32'(mem_err), 0);
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr = 1'b0;
    reset = 1'b0;
    step();
    // plain fetch, minimum latency
    step(); inst_req = 1'b1; inst_addr = 32'h1C00_0000; push(0, 32'h0280_0C0C); #1;
    chk("t1 inst_addr_ok@T", 32'(inst_addr_ok), 1);
    chk("t1 data_addr_ok@T", 32'(data_addr_ok), 0);
    step(); inst_req = 1'b0; #1;
    chk("t1 mem_req@T+1", 32'(mem_req), 1);
    chk("t1 mem_addr", mem_addr, 32'h1C00_0000);
    chk("t1 mem_we", 32'(mem_we), 0);
    step(); #1;
    chk("t1 mem_req@T+2", 32'(mem_req), 0);
    step(); #1;
    chk("t1 inst_data_ok@T+3", 32'(inst_data_ok), 1);
    chk("t1 inst_rdata", inst_rdata, 32'h0280_0C0C);
    chk("t1 mem_err", 32'(mem_err), 0);
    step(); #1;
    chk("t1 data_ok pulse", 32'(inst_data_ok), 0);
    // simultaneous requests: data first
    step(); inst_req = 1'b1; inst_addr = 32'h1C00_0004; data_req = 1'b1; data_wr = 1'b0;
    data_addr = 32'h0000_0200; push(1, 32'hCAFE_F00D); push(0, 32'h1234_5678); #1;
    chk("t2 data_addr_ok@T", 32'(data_addr_ok), 1);
    chk("t2 inst_addr_ok@T", 32'(inst_addr_ok), 0);
    step(); data_req = 1'b0; #1;
    chk("t2 mem_addr data", mem_addr, 32'h0000_0200);
    chk("t2 inst held off", 32'(inst_addr_ok), 0);
    step(); step(); #1;
    chk("t2 data_data_ok@T+3", 32'(data_data_ok), 1);
    chk("t2 inst_data_ok@T+3", 32'(inst_data_ok), 0);
    chk("t2 data_rdata", data_rdata, 32'hCAFE_F00D);
    step(); #1;
    chk("t2 inst_addr_ok@T+4", 32'(inst_addr_ok), 1);
    step(); inst_req = 1'b0; #1;
    chk("t2 mem_addr inst", mem_addr, 32'h1C00_0004);
    wait_dok("t2 inst done bound");
    chk("t2 inst_data_ok", 32'(inst_data_ok), 1);
    chk("t2 inst_rdata", inst_rdata, 32'h1234_5678);
    // partial store
    step(); data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_addr = 32'h0000_0100;
    data_wdata = 32'hAABB_CCDD; push(1, 32'hCAFE_F00D); #1;
    chk("t3 data_addr_ok", 32'(data_addr_ok), 1);
    step(); data_req = 1'b0; data_wr = 1'b0; #1;
    chk("t3 mem_we", 32'(mem_we), 32'h3);
    chk("t3 mem_wdata", mem_wdata, 32'hAABB_CCDD);
    chk("t3 mem_addr", mem_addr, 32'h0000_0100);
    wait_dok("t3 store done bound");
    chk("t3 data_data_ok", 32'(data_data_ok), 1);
    chk("t3 data_rdata kept", data_rdata, 32'hCAFE_F00D);
    // stalled grant with a competing data request
    step(); stall = 5; inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    push(0, 32'h0280_0C0C); push(1, 32'hCAFE_F00D); #1;
    chk("t4 inst_addr_ok", 32'(inst_addr_ok), 1);
    step(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0200;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      #1;
      chk($sformatf("t4 mem_req c%0d", i), 32'(mem_req), 1);
      chk($sformatf("t4 mem_addr c%0d", i), mem_addr, 32'h1C00_0000);
      chk($sformatf("t4 no addr_ok c%0d", i), 32'(data_addr_ok), 0);
    end
    step(); stall = 0; #1;
    chk("t4 mem_req dropped", 32'(mem_req), 0);
    step(); #1;
    chk("t4 inst_data_ok", 32'(inst_data_ok), 1);
    step(); #1;
    chk("t4 data_addr_ok after", 32'(data_addr_ok), 1);
    step(); data_req = 1'b0; #1;
    wait_dok("t4 data done bound");
    chk("t4 data_data_ok", 32'(data_data_ok), 1);
    // stray rvalid while idle must be ignored
    step(); stray = 1'b1;
    step(); step(); stray = 1'b0;
    step(); step(); #1;
    chk("stray inst_data_ok", 32'(inst_data_ok), 0);
    chk("stray data_data_ok", 32'(data_data_ok), 0);
    chk("stray inst_rdata", inst_rdata, 32'h0280_0C0C);
    // reset while waiting in RESP
    step(); resp_en = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0004; #1;
    chk("t5 inst_addr_ok", 32'(inst_addr_ok), 1);
    step(); inst_req = 1'b0;
    step(); step(); #1;
    chk("t5 no data_ok in RESP", 32'(inst_data_ok), 0);
    chk("t5 mem_addr before", mem_addr, 32'h1C00_0004);
    data_req = 1'b1;
    reset = 1'b1; #1;
    chk("t5 mem_addr async", mem_addr, 0);
    chk("t5 mem_req", 32'(mem_req), 0);
    chk("t5 data_addr_ok", 32'(data_addr_ok), 0);
    chk("t5 inst_rdata cleared", inst_rdata, 0);
    step(); data_req = 1'b0; reset = 1'b0; resp_en = 1'b1;
    step(); step(); #1;
    chk("t5 nothing after reset", 32'(inst_data_ok | data_data_ok), 0);
    step(); inst_req = 1'b1; inst_addr = 32'h1C00_0000; push(0, 32'h0280_0C0C); #1;
    chk("t5 idle after reset", 32'(inst_addr_ok), 1);
    step(); inst_req = 1'b0; #1;
    wait_dok("t5 fetch done bound");
    chk("t5 inst_rdata", inst_rdata, 32'h0280_0C0C);
`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog: no response ever arrives
    step(); resp_en = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0000; push(0, 32'h0); #1;
    chk("to inst_addr_ok", 32'(inst_addr_ok), 1);
    step(); inst_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(); #1;
      chk($sformatf("to waiting c%0d", i), 32'(inst_data_ok | mem_err), 0);
    end
    step(); #1;
    chk("to inst_data_ok", 32'(inst_data_ok), 1);
    chk("to mem_err", 32'(mem_err), 1);
    chk("to inst_rdata", inst_rdata, 0);
    step(); resp_en = 1'b1; #1;
    chk("to mem_err pulse", 32'(mem_err), 0);
    chk("to idle", 32'(mem_req | inst_data_ok), 0);
`endif
    step(); step(); #1;
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", serr + merr, schk + mchk);
    $finish;
  end
endmodule
